// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one req/ack memory port between instruction
// fetch and the data path (LD/ST/PUSH/POP), one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    // data requester
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    // pipeline
    output logic              stall,
    // external memory
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    state_t state;
    grant_t last_grant;

    logic d_pend;
    logic pick_data;

    // Data side is pending on either a load or a store request.
    always_comb begin
        d_pend = d_rd | d_wr;
    end

    // Data wins when it is alone, or when both wait and fetch had the last turn.
    always_comb begin
        pick_data = d_pend & (~if_req | (last_grant == GRANT_FETCH));
    end

    // Stall the pipeline while any requester is still waiting for its completion.
    always_comb begin
        stall = (d_pend & ~d_valid) | (if_req & ~if_valid);
    end

    // Arbitration FSM with registered memory-port and requester outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_DATA;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_data) begin
                        state      <= D_BUSY;
                        last_grant <= GRANT_DATA;
                        mem_req    <= 1'b1;
                        // A simultaneous read and write is illegal; the write wins.
                        mem_we     <= d_wr;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                    end else if (if_req) begin
                        state      <= IF_BUSY;
                        last_grant <= GRANT_FETCH;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between instruction fetch and the data path.
- Data accesses come from the decoder's memrd/memwr: LD, ST, PUSH and POP.
- Serialises the two requesters with one transaction outstanding at a time, and handles variable memory latency with a req/ack handshake.
- Drives the pipeline stall while any requester is waiting. It sits between the fetch stage, the MEM stage and the external memory.

Parameters:
- ADDR_W, 16, address width of every address port.
- DATA_W, 16, data width of every data port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; level, held until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  ADDR_W-independent DATA_W  fetched word; registered.
- if_valid  out  1  one-cycle pulse: if_rdata is valid and the fetch is complete.
- d_rd  in  1  data read request (memrd); level, held until d_valid.
- d_wr  in  1  data write request (memwr); level, held until d_valid.
- d_addr  in  ADDR_W  data address; stable while a request is high.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered.
- d_valid  out  1  one-cycle pulse: data access complete (reads and writes).
- stall  out  1  pipeline stall.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state goes to IDLE; mem_req, mem_we, if_valid, d_valid go to 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata go to 0; last_grant goes to DATA.
  - Reset overrides any in-flight transaction. An ack arriving after reset, with mem_req=0, is ignored.
- States: IDLE, IF_BUSY, D_BUSY.
- Data pending is defined as d_rd | d_wr.
- In IDLE, at the edge:
  - Data pending only: go to D_BUSY.
  - if_req only: go to IF_BUSY.
  - Both pending: grant the requester not equal to last_grant, so the two alternate and neither starves.
  - On entry, register mem_req=1, mem_addr, mem_we, and mem_wdata (data grant only).
  - mem_we = d_wr. If d_rd and d_wr are both high, this is illegal; the write wins.
  - last_grant is updated to the granted side.
- In IF_BUSY or D_BUSY:
  - mem_req, mem_addr, mem_we and mem_wdata stay constant until mem_ack=1 is sampled.
  - At the edge where mem_ack=1: mem_req goes to 0 and the state returns to IDLE.
  - At that same edge, the granted side's valid is set for exactly one cycle.
  - For a read, mem_rdata is captured into if_rdata or d_rdata. A write leaves d_rdata unchanged.
- After every completion there is one IDLE cycle, so back-to-back grants are separated by at least one cycle with mem_req=0.
- Latency: request seen in IDLE at edge N gives mem_req=1 from N to N+1. An ack present in that first cycle gives valid in cycle N+1 to N+2. The minimum is 2 cycles from request to valid.
- Unbounded wait: mem_ack may stay low indefinitely. The block holds its state, and there is no timeout.
- stall (combinational) = (data pending & ~d_valid) | (if_req & ~if_valid).
- Requester drop: if a requester drops its request before valid, the transaction still completes and valid still pulses. Requesters must not do this; it is a protocol violation.
- mem_ack while in IDLE is ignored.
- Outputs if_valid and d_valid are never high in the same cycle.

Test Plan:
- Reset and single fetch:
  - Stimulus: rst_n=0 for 2 cycles, then if_req=1, if_addr=0x0040; memory acks 3 cycles after mem_req rises with rdata=0xA5C3.
  - Required: all outputs are 0 during reset; mem_req=1, mem_we=0, mem_addr=0x0040 held for 3 cycles; then one cycle of if_valid=1 with if_rdata=0xA5C3; stall=1 until that cycle.
- Store:
  - Stimulus: d_wr=1, d_addr=0x1FFE, d_wdata=0xBEEF; same-cycle ack.
  - Required: mem_we=1, mem_wdata=0xBEEF; d_valid pulses 2 cycles after the request; d_rdata stays 0.
- Contention:
  - Stimulus: if_req and d_rd held continuously with last_grant=DATA after reset.
  - Required: grant order is fetch, data, fetch, data; each completion is followed by one cycle of mem_req=0.
- Illegal both:
  - Stimulus: d_rd=1 and d_wr=1.
  - Required: mem_we=1; exactly one d_valid pulse.
- Reset mid-transaction:
  - Stimulus: assert rst_n=0 in D_BUSY before ack; then ack=1 one cycle after reset deasserts, with no request pending.
  - Required: mem_req=0 the cycle after reset; no d_valid pulse; the late ack is ignored; state is IDLE.
- Long wait:
  - Stimulus: ack withheld for 50 cycles.
  - Required: mem_addr stable throughout; stall=1 for all 50 cycles; a single valid pulse after the ack.
